// File: rtl/pattern_lock_prog_if.sv
// Bus between the serial key source / actuator-enable logic and pattern_lock_prog.
// Widths are derived from the same parameters the lock core uses, so instantiate both with matching values.
interface pattern_lock_prog_if #(
  parameter int PAT_W    = 4,
  parameter int MAX_FAIL = 3
);
  logic                            in;
  logic                            in_valid;
  logic                            lock;
  logic                            pat_load;
  logic [PAT_W-1:0]                pat_in;
  logic                            out;
  logic                            lock_out;
  logic [$clog2(MAX_FAIL+1)-1:0]   fail_cnt;
  logic [$clog2(PAT_W+1)-1:0]      bit_cnt;

  modport master (
    output in, in_valid, lock, pat_load, pat_in,
    input  out, lock_out, fail_cnt, bit_cnt
  );

  modport slave (
    input  in, in_valid, lock, pat_load, pat_in,
    output out, lock_out, fail_cnt, bit_cnt
  );
endinterface

// File: rtl/pattern_lock_prog.sv
// Serial pattern lock with a programmable key: MSB-first frames of PAT_W bits,
// unlock on match, timed lockout after MAX_FAIL consecutive mismatches.
//
// state    | meaning
// ---------+---------------------------------------------------------
// LOCKED   | collecting frame bits, comparing each full frame to key
// UNLOCKED | out high; accepts re-lock and key reload
// LOCKOUT  | lock_out high for LOCKOUT_CYCLES cycles, inputs ignored
module pattern_lock_prog #(
  parameter int               PAT_W          = 4,
  parameter logic [PAT_W-1:0] DEFAULT_PAT    = 4'b1101,
  parameter int               MAX_FAIL       = 3,
  parameter int               LOCKOUT_CYCLES = 16
) (
  input  logic                clk,
  input  logic                rst,
  pattern_lock_prog_if.slave  bus
);
  localparam int FW = $clog2(MAX_FAIL+1);
  localparam int BW = $clog2(PAT_W+1);
  localparam int TW = $clog2(LOCKOUT_CYCLES+1);

  localparam logic [FW-1:0] MAX_FAIL_C  = FW'(MAX_FAIL);
  localparam logic [BW-1:0] LAST_BIT_C  = BW'(PAT_W-1);
  localparam logic [TW-1:0] TIMER_INIT  = TW'(LOCKOUT_CYCLES-1);

  typedef enum logic [1:0] {
    LOCKED   = 2'd0,
    UNLOCKED = 2'd1,
    LOCKOUT  = 2'd2
  } state_t;

  state_t           state_q;
  logic [PAT_W-1:0] key_q;
  logic [PAT_W-1:0] shreg_q;
  logic [BW-1:0]    bit_cnt_q;
  logic [FW-1:0]    fail_cnt_q;
  logic [TW-1:0]    timer_q;
  logic             out_q;
  logic             lock_out_q;

  // Frame including the bit arriving this cycle, so the compare needs no extra cycle.
  logic [PAT_W-1:0] frame_d;
  assign frame_d = {shreg_q[PAT_W-2:0], bus.in};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= LOCKED;
      key_q      <= DEFAULT_PAT;
      shreg_q    <= '0;
      bit_cnt_q  <= '0;
      fail_cnt_q <= '0;
      timer_q    <= '0;
      out_q      <= 1'b0;
      lock_out_q <= 1'b0;
    end else begin
      case (state_q)
        LOCKED: begin
          if (bus.in_valid) begin
            if (bit_cnt_q == LAST_BIT_C) begin
              bit_cnt_q <= '0;
              shreg_q   <= '0;
              if (frame_d == key_q) begin
                state_q    <= UNLOCKED;
                out_q      <= 1'b1;
                fail_cnt_q <= '0;
              end else if (fail_cnt_q + FW'(1) == MAX_FAIL_C) begin
                state_q    <= LOCKOUT;
                lock_out_q <= 1'b1;
                timer_q    <= TIMER_INIT;
                fail_cnt_q <= MAX_FAIL_C;
              end else begin
                fail_cnt_q <= fail_cnt_q + FW'(1);
              end
            end else begin
              shreg_q   <= frame_d;
              bit_cnt_q <= bit_cnt_q + BW'(1);
            end
          end
        end
        UNLOCKED: begin
          shreg_q   <= '0;
          bit_cnt_q <= '0;
          if (bus.pat_load) key_q <= bus.pat_in;
          if (bus.lock) begin
            state_q <= LOCKED;
            out_q   <= 1'b0;
          end
        end
        LOCKOUT: begin
          if (timer_q == '0) begin
            state_q    <= LOCKED;
            lock_out_q <= 1'b0;
            fail_cnt_q <= '0;
            bit_cnt_q  <= '0;
            shreg_q    <= '0;
          end else begin
            timer_q <= timer_q - TW'(1);
          end
        end
        default: begin
          state_q    <= LOCKED;
          out_q      <= 1'b0;
          lock_out_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.out      = out_q;
  assign bus.lock_out = lock_out_q;
  assign bus.fail_cnt = fail_cnt_q;
  assign bus.bit_cnt  = bit_cnt_q;
endmodule

// File: tb/tb_pattern_lock_prog.sv
// Directed bench for pattern_lock_prog: expected outputs are queued with each
// driven cycle and compared one cycle later, just after the clock edge.
module tb_pattern_lock_prog;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  pattern_lock_prog_if #(.PAT_W(4), .MAX_FAIL(3)) bus ();

  pattern_lock_prog #(
    .PAT_W(4), .DEFAULT_PAT(4'b1101), .MAX_FAIL(3), .LOCKOUT_CYCLES(16)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    string      tag;
    logic       o;
    logic       lo;
    logic [1:0] fc;
    logic [2:0] bc;
  } exp_t;

  exp_t sb[$];

  task automatic check();
    exp_t e;
    if (sb.size() == 0) begin
      total++; bad++;
      $error("FAIL scoreboard_empty observed=0 expected=1");
      return;
    end
    e = sb.pop_front();
    total++;
    assert (bus.out === e.o) else begin
      bad++; $error("FAIL %s.out observed=%b expected=%b", e.tag, bus.out, e.o);
    end
    total++;
    assert (bus.lock_out === e.lo) else begin
      bad++; $error("FAIL %s.lock_out observed=%b expected=%b", e.tag, bus.lock_out, e.lo);
    end
    total++;
    assert (bus.fail_cnt === e.fc) else begin
      bad++; $error("FAIL %s.fail_cnt observed=%0d expected=%0d", e.tag, bus.fail_cnt, e.fc);
    end
    total++;
    assert (bus.bit_cnt === e.bc) else begin
      bad++; $error("FAIL %s.bit_cnt observed=%0d expected=%0d", e.tag, bus.bit_cnt, e.bc);
    end
  endtask

  // Drive one cycle of inputs, queue the expected post-edge outputs, then compare.
  task automatic step(input logic r, input logic v, input logic b, input logic lk,
                      input logic ld, input logic [3:0] p, input string tag,
                      input logic eo, input logic elo, input logic [1:0] efc,
                      input logic [2:0] ebc);
    exp_t e;
    rst          = r;
    bus.in_valid = v;
    bus.in       = b;
    bus.lock     = lk;
    bus.pat_load = ld;
    bus.pat_in   = p;
    e.tag = tag; e.o = eo; e.lo = elo; e.fc = efc; e.bc = ebc;
    sb.push_back(e);
    @(posedge clk);
    #1;
    check();
  endtask

  task automatic frame(input logic [3:0] bits, input string tag, input logic [1:0] fb,
                       input logic eo, input logic elo, input logic [1:0] ef);
    for (int i = 0; i < 4; i++) begin
      if (i < 3) step(0, 1, bits[3-i], 0, 0, 4'h0, tag, 0, 0, fb, 3'(i + 1));
      else       step(0, 1, bits[0],   0, 0, 4'h0, tag, eo, elo, ef, 3'd0);
    end
  endtask

  initial begin
    logic [3:0] junk;
    junk = 4'b1101;
    bus.in = 0; bus.in_valid = 0; bus.lock = 0; bus.pat_load = 0; bus.pat_in = '0;

    step(1, 0, 0, 0, 0, 4'h0, "reset1", 0, 0, 2'd0, 3'd0);
    step(1, 1, 1, 1, 1, 4'hF, "reset2", 0, 0, 2'd0, 3'd0);

    frame(4'b1101, "correct_key", 2'd0, 1, 0, 2'd0);
    step(0, 0, 0, 1, 0, 4'h0, "relock", 0, 0, 2'd0, 3'd0);

    step(0, 1, 1, 0, 0, 4'h0, "gap_b0", 0, 0, 2'd0, 3'd1);
    for (int i = 0; i < 3; i++) step(0, 0, 1, 0, 0, 4'h0, "gap_idle", 0, 0, 2'd0, 3'd1);
    step(0, 1, 1, 0, 0, 4'h0, "gap_b1", 0, 0, 2'd0, 3'd2);
    step(0, 1, 0, 0, 0, 4'h0, "gap_b2", 0, 0, 2'd0, 3'd3);
    step(0, 1, 1, 0, 0, 4'h0, "gap_b3", 1, 0, 2'd0, 3'd0);
    step(0, 1, 1, 0, 1, 4'h3, "unlocked_load_only", 1, 0, 2'd0, 3'd0);
    step(0, 0, 0, 1, 1, 4'b1101, "relock_keep_key", 0, 0, 2'd0, 3'd0);

    frame(4'b0000, "fail1", 2'd0, 0, 0, 2'd1);
    frame(4'b1101, "succ_after_fail", 2'd1, 1, 0, 2'd0);
    step(0, 0, 0, 1, 0, 4'h0, "relock2", 0, 0, 2'd0, 3'd0);

    frame(4'b1111, "lo_f1", 2'd0, 0, 0, 2'd1);
    frame(4'b0000, "lo_f2", 2'd1, 0, 0, 2'd2);
    frame(4'b1010, "lo_f3", 2'd2, 0, 1, 2'd3);
    for (int i = 1; i < 16; i++)
      step(0, 1, junk[3 - (i % 4)], 1, 1, 4'h0, "lockout_hold", 0, 1, 2'd3, 3'd0);
    step(0, 0, 0, 0, 0, 4'h0, "lockout_exit", 0, 0, 2'd0, 3'd0);
    frame(4'b1101, "after_lockout", 2'd0, 1, 0, 2'd0);

    step(0, 0, 0, 1, 1, 4'b0110, "rekey_lock", 0, 0, 2'd0, 3'd0);
    frame(4'b1101, "old_key_fails", 2'd0, 0, 0, 2'd1);
    frame(4'b0110, "new_key", 2'd1, 1, 0, 2'd0);
    step(0, 0, 0, 1, 0, 4'h0, "relock3", 0, 0, 2'd0, 3'd0);

    step(0, 1, 0, 0, 0, 4'h0, "mid_b0", 0, 0, 2'd0, 3'd1);
    step(0, 1, 1, 0, 0, 4'h0, "mid_b1", 0, 0, 2'd0, 3'd2);
    step(1, 1, 1, 0, 0, 4'h0, "rst_mid_frame", 0, 0, 2'd0, 3'd0);
    frame(4'b1101, "default_key_back", 2'd0, 1, 0, 2'd0);
    step(0, 0, 0, 1, 0, 4'h0, "relock4", 0, 0, 2'd0, 3'd0);

    frame(4'b0001, "lo2_f1", 2'd0, 0, 0, 2'd1);
    frame(4'b0010, "lo2_f2", 2'd1, 0, 0, 2'd2);
    frame(4'b0100, "lo2_f3", 2'd2, 0, 1, 2'd3);
    step(0, 0, 0, 0, 0, 4'h0, "lo2_hold", 0, 1, 2'd3, 3'd0);
    step(1, 0, 0, 0, 0, 4'h0, "rst_in_lockout", 0, 0, 2'd0, 3'd0);

    frame(4'b1101, "unlock_pre_rekey", 2'd0, 1, 0, 2'd0);
    step(0, 0, 0, 1, 1, 4'b0110, "rekey2", 0, 0, 2'd0, 3'd0);
    step(1, 0, 0, 0, 0, 4'h0, "rst_after_rekey", 0, 0, 2'd0, 3'd0);
    frame(4'b1101, "key_reset_default", 2'd0, 1, 0, 2'd0);
    step(0, 0, 0, 1, 0, 4'h0, "relock5", 0, 0, 2'd0, 3'd0);
    frame(4'b0110, "stale_key_fails", 2'd0, 0, 0, 2'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end
endmodule
